fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the pipelined MIPS datapath. It owns the program counter, drives the instruction-memory request, applies redirects selected by the control path, and fills the IF/ID pipeline register. It sits directly upstream of the hazard unit. It consumes the hazard unit's `pcen`, `hazen` and `imemREN_out` outputs, and feeds the hazard unit's `ifid_rs_l` and `ifid_rt_l` inputs through the registered IF/ID fields.

## Interface
Parameters:
- `PC_INIT`, default `32'h0000_0000`: PC value loaded on reset.
- `CNT_W`, default `32`: width of the fetch performance counter.

Ports:
- `CLK`, in, 1: system clock; all state updates on the rising edge.
- `RST`, in, 1: asynchronous, active-high reset.
- `ihit`, in, 1: instruction memory returned `imemload` this cycle.
- `imemload`, in, 32: instruction word from memory.
- `imemREN_in`, in, 1: fetch permission from the hazard unit's `imemREN_out`.
- `pcen`, in, 1: PC advance enable from the hazard unit.
- `hazen`, in, 1: stall; IF/ID holds its contents.
- `flush`, in, 1: redirect taken; squash IF/ID and load the target.
- `pcsrc`, in, 3: redirect select.
  - 0: PC+4
  - 1: `branch_target`
  - 2: `jump_target`
  - 3: `jr_target`
  - 4–7: PC+4
- `branch_target`, `jump_target`, `jr_target`, in, 32 each: redirect addresses, word aligned.
- `halt`, in, 1: HALT instruction reached writeback.
- `imemaddr`, out, 32: current PC.
- `imemREN`, out, 1: instruction-memory read request.
- `ifid_instr`, out, 32: registered instruction.
- `ifid_npc`, out, 32: registered PC+4 of `ifid_instr`.
- `ifid_valid`, out, 1: `ifid_instr` is a real instruction, not a bubble.
- `ifid_rs`, out, 5: `ifid_instr[25:21]`.
- `ifid_rt`, out, 5: `ifid_instr[20:16]`.
- `fetch_count`, out, `CNT_W`: number of valid instructions loaded into IF/ID.
- `halted`, out, 1: the unit is in the HALTED state.

## Operation
- States: RUN and HALTED. Reset enters RUN.
- RUN → HALTED on `halt`=1. HALTED is left only by reset.
- `imemREN` = (state==RUN) & `imemREN_in` & ~`RST`.
- `imemaddr` = PC register. `npc` = PC + 32'd4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- PC update priority, first match wins:
  1. HALTED: hold.
  2. `flush`=1: PC ← target selected by `pcsrc`. This ignores `ihit` and `pcen`.
  3. `ihit` & `pcen`: PC ← `npc`.
  4. Otherwise: hold.
- IF/ID update priority, first match wins:
  1. HALTED or `flush`: load a bubble (`instr`=0, `npc`=0, `valid`=0).
  2. `hazen`: hold all fields.
  3. `ihit`: load `imemload` and `npc`, with `valid`=1.
  4. Otherwise (fetch still pending): load a bubble.
- Under `flush`, an `ihit` arriving in the same cycle is discarded.
- `fetch_count` increments by 1 on each cycle with case 3 of the IF/ID update. It wraps at 2^`CNT_W`.
- `ifid_rs` and `ifid_rt` are wired slices of the `ifid_instr` register.

## Timing
- Reset values:
  - PC = `PC_INIT`, so `imemaddr` = `PC_INIT`.
  - `ifid_instr` = 0, `ifid_npc` = 0, `ifid_valid` = 0.
  - `fetch_count` = 0, `halted` = 0.
  - `imemREN` = 0 while `RST` is high.
- Latency: an instruction accepted on cycle N with `ihit`=1 appears on the `ifid_*` outputs in cycle N+1.
- Memory handshake:
  - The address is held stable until `ihit`, unless a flush occurs.
  - Multi-cycle memory produces bubbles into IF/ID while waiting.
- Redirect: the target appears on `imemaddr` in the cycle after `flush`. IF/ID shows a bubble in that same cycle.
- Simultaneous events:
  - `flush`+`hazen`: flush wins.
  - `halt`+`flush`: halt wins; PC holds.
  - `hazen` with `pcen`=0 and `ihit`=1: PC and IF/ID both hold. The same word is refetched.
- Reset asserted mid-fetch: all state returns to reset values immediately, without waiting for a clock edge.

## Test plan
- Reset then single-cycle memory (`ihit`=1 every cycle, `pcen`=1), `PC_INIT`=0:
  - `imemaddr` = 0, 4, 8 on successive cycles.
  - `ifid_npc` = 4, 8, 12, one cycle behind.
  - `fetch_count` = 3 after 3 cycles.
- Wait states: `ihit` low for 2 cycles, then high at PC=0x10:
  - PC holds 0x10 for 3 cycles.
  - IF/ID shows 2 bubbles, then the instruction with `npc`=0x14.
- Stall: `hazen`=1 and `pcen`=0 for 2 cycles with instruction 0x8C220004 in IF/ID:
  - `ifid_instr`, `ifid_rs`=1 and `ifid_rt`=2 are held.
  - PC is unchanged and `fetch_count` is unchanged.
- Branch redirect: `flush`=1, `pcsrc`=1, `branch_target`=0x40, with `ihit`=1 in the same cycle:
  - Next cycle `imemaddr` = 0x40 and `ifid_valid` = 0.
  - The discarded word is not counted.
- Jump and JR: `pcsrc`=2 with `jump_target`=0x100, then `pcsrc`=3 with `jr_target`=0x200:
  - PC follows each target.
  - `pcsrc`=5 with `flush` gives PC+4.
- Halt then reset:
  - `halt`=1 → `halted`=1, `imemREN`=0, PC frozen, IF/ID bubbles. The unit stays there despite `flush`.
  - Asserting `RST` asynchronously mid-cycle clears everything to reset values at once.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-stage bus: memory handshake, hazard/redirect controls and IF/ID outputs.
// The master side belongs to fetch_unit; the slave side is the surrounding pipeline.
interface fetch_if #(
    parameter int unsigned CNT_W = 32
);
    logic              ihit;
    logic [31:0]       imemload;
    logic              imemREN_in;
    logic              pcen;
    logic              hazen;
    logic              flush;
    logic [2:0]        pcsrc;
    logic [31:0]       branch_target;
    logic [31:0]       jump_target;
    logic [31:0]       jr_target;
    logic              halt;
    logic [31:0]       imemaddr;
    logic              imemREN;
    logic [31:0]       ifid_instr;
    logic [31:0]       ifid_npc;
    logic              ifid_valid;
    logic [4:0]        ifid_rs;
    logic [4:0]        ifid_rt;
    logic [CNT_W-1:0]  fetch_count;
    logic              halted;

    modport master (
        input  ihit, imemload, imemREN_in, pcen, hazen, flush, pcsrc,
               branch_target, jump_target, jr_target, halt,
        output imemaddr, imemREN, ifid_instr, ifid_npc, ifid_valid,
               ifid_rs, ifid_rt, fetch_count, halted
    );

    modport slave (
        output ihit, imemload, imemREN_in, pcen, hazen, flush, pcsrc,
               branch_target, jump_target, jr_target, halt,
        input  imemaddr, imemREN, ifid_instr, ifid_npc, ifid_valid,
               ifid_rs, ifid_rt, fetch_count, halted
    );
endinterface

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: PC register, redirect mux, IF/ID register,
// fetch counter and a RUN/HALTED state machine.
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int unsigned CNT_W   = 32
) (
    input  logic      CLK,
    input  logic      RST,
    fetch_if.master   bus
);
    localparam int unsigned XLEN = 32;
    localparam logic [0:0] RUN    = 1'b0;
    localparam logic [0:0] HALTED = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] npc_q, npc_d;
    logic            valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [XLEN-1:0] npc_c;
    logic [XLEN-1:0] target_c;
    logic            stop_c;

    // State registers; reset takes effect immediately
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= RUN;
            pc_q    <= PC_INIT;
            instr_q <= '0;
            npc_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            npc_q   <= npc_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        npc_d    = npc_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        npc_c    = pc_q + XLEN'(4);
        target_c = npc_c;

        // A halt arriving this cycle already freezes the stage, beating any flush
        stop_c = (state_q == HALTED) || bus.halt;

        if (state_q == RUN && bus.halt) begin
            state_d = HALTED;
        end

        case (bus.pcsrc)
            3'd1:    target_c = bus.branch_target;
            3'd2:    target_c = bus.jump_target;
            3'd3:    target_c = bus.jr_target;
            default: target_c = npc_c;
        endcase

        if (!stop_c) begin
            if (bus.flush) begin
                pc_d = target_c;
            end else if (bus.ihit && bus.pcen) begin
                pc_d = npc_c;
            end
        end

        if (stop_c || bus.flush) begin
            instr_d = '0;
            npc_d   = '0;
            valid_d = 1'b0;
        end else if (bus.hazen) begin
            instr_d = instr_q;
        end else if (bus.ihit) begin
            instr_d = bus.imemload;
            npc_d   = npc_c;
            valid_d = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
        end else begin
            instr_d = '0;
            npc_d   = '0;
            valid_d = 1'b0;
        end
    end

    assign bus.imemaddr    = pc_q;
    assign bus.imemREN     = (state_q == RUN) && bus.imemREN_in && !RST;
    assign bus.ifid_instr  = instr_q;
    assign bus.ifid_npc    = npc_q;
    assign bus.ifid_valid  = valid_q;
    assign bus.ifid_rs     = instr_q[25:21];
    assign bus.ifid_rt     = instr_q[20:16];
    assign bus.fetch_count = cnt_q;
    assign bus.halted      = (state_q == HALTED);
endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    fetch_if #(.CNT_W(32)) bus ();

    fetch_unit #(.PC_INIT(32'h0000_0000), .CNT_W(32)) u_dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        bus.ihit = 1'b0;
        bus.imemload = 32'h0;
        bus.imemREN_in = 1'b1;
        bus.pcen = 1'b0;
        bus.hazen = 1'b0;
        bus.flush = 1'b0;
        bus.pcsrc = 3'd0;
        bus.branch_target = 32'h0;
        bus.jump_target = 32'h0;
        bus.jr_target = 32'h0;
        bus.halt = 1'b0;

        // Reset state
        #12;
        check_eq("rst_pc", bus.imemaddr, 32'h0);
        check_eq("rst_ren", 32'(bus.imemREN), 32'h0);
        check_eq("rst_valid", 32'(bus.ifid_valid), 32'h0);
        check_eq("rst_instr", bus.ifid_instr, 32'h0);
        check_eq("rst_cnt", bus.fetch_count, 32'h0);
        check_eq("rst_halted", 32'(bus.halted), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("run_ren", 32'(bus.imemREN), 32'h1);

        // Single-cycle memory
        bus.ihit = 1'b1;
        bus.pcen = 1'b1;
        bus.imemload = 32'h2001_0001;
        check_eq("seq_pc0", bus.imemaddr, 32'h0);
        step();
        check_eq("seq_pc1", bus.imemaddr, 32'h4);
        check_eq("seq_npc1", bus.ifid_npc, 32'h4);
        check_eq("seq_instr1", bus.ifid_instr, 32'h2001_0001);
        step();
        check_eq("seq_pc2", bus.imemaddr, 32'h8);
        check_eq("seq_npc2", bus.ifid_npc, 32'h8);
        step();
        check_eq("seq_npc3", bus.ifid_npc, 32'hC);
        check_eq("seq_cnt3", bus.fetch_count, 32'd3);
        step();
        check_eq("seq_pc4", bus.imemaddr, 32'h10);

        // Wait states at PC=0x10
        bus.ihit = 1'b0;
        step();
        check_eq("ws_pc1", bus.imemaddr, 32'h10);
        check_eq("ws_bub1", 32'(bus.ifid_valid), 32'h0);
        step();
        check_eq("ws_pc2", bus.imemaddr, 32'h10);
        check_eq("ws_bub2", 32'(bus.ifid_valid), 32'h0);
        check_eq("ws_cnt", bus.fetch_count, 32'd4);
        bus.ihit = 1'b1;
        bus.imemload = 32'h8C22_0004;
        step();
        check_eq("ws_pc3", bus.imemaddr, 32'h14);
        check_eq("ws_instr", bus.ifid_instr, 32'h8C22_0004);
        check_eq("ws_npc", bus.ifid_npc, 32'h14);
        check_eq("ws_valid", 32'(bus.ifid_valid), 32'h1);
        check_eq("ws_cnt5", bus.fetch_count, 32'd5);

        // Stall: IF/ID and PC hold while a different word is presented
        bus.hazen = 1'b1;
        bus.pcen = 1'b0;
        bus.imemload = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq("stl_instr", bus.ifid_instr, 32'h8C22_0004);
            check_eq("stl_rs", 32'(bus.ifid_rs), 32'd1);
            check_eq("stl_rt", 32'(bus.ifid_rt), 32'd2);
            check_eq("stl_pc", bus.imemaddr, 32'h14);
            check_eq("stl_cnt", bus.fetch_count, 32'd5);
        end

        // Branch redirect with a coincident ihit
        bus.hazen = 1'b0;
        bus.pcen = 1'b1;
        bus.flush = 1'b1;
        bus.pcsrc = 3'd1;
        bus.branch_target = 32'h40;
        step();
        check_eq("br_pc", bus.imemaddr, 32'h40);
        check_eq("br_valid", 32'(bus.ifid_valid), 32'h0);
        check_eq("br_instr", bus.ifid_instr, 32'h0);
        check_eq("br_cnt", bus.fetch_count, 32'd5);

        // Jump ignores pcen; JR with hazen still flushes; pcsrc=5 selects PC+4
        bus.pcsrc = 3'd2;
        bus.jump_target = 32'h100;
        bus.pcen = 1'b0;
        step();
        check_eq("j_pc", bus.imemaddr, 32'h100);
        bus.pcsrc = 3'd3;
        bus.jr_target = 32'h200;
        bus.hazen = 1'b1;
        step();
        check_eq("jr_pc", bus.imemaddr, 32'h200);
        check_eq("jr_valid", 32'(bus.ifid_valid), 32'h0);
        bus.hazen = 1'b0;
        bus.pcsrc = 3'd5;
        step();
        check_eq("ps5_pc", bus.imemaddr, 32'h204);

        // PC+4 wraps from 0xFFFF_FFFC to 0
        bus.pcsrc = 3'd3;
        bus.jr_target = 32'hFFFF_FFFC;
        step();
        check_eq("wr_pc", bus.imemaddr, 32'hFFFF_FFFC);
        bus.flush = 1'b0;
        bus.pcen = 1'b1;
        bus.imemload = 32'h1234_5678;
        step();
        check_eq("wr_pc0", bus.imemaddr, 32'h0);
        check_eq("wr_npc", bus.ifid_npc, 32'h0);
        check_eq("wr_valid", 32'(bus.ifid_valid), 32'h1);
        check_eq("wr_cnt", bus.fetch_count, 32'd6);
        step();
        check_eq("pre_halt_pc", bus.imemaddr, 32'h4);

        // Halt beats a simultaneous flush and persists
        bus.halt = 1'b1;
        bus.flush = 1'b1;
        bus.pcsrc = 3'd1;
        step();
        check_eq("h_halted", 32'(bus.halted), 32'h1);
        check_eq("h_ren", 32'(bus.imemREN), 32'h0);
        check_eq("h_pc", bus.imemaddr, 32'h4);
        check_eq("h_valid", 32'(bus.ifid_valid), 32'h0);
        check_eq("h_cnt", bus.fetch_count, 32'd7);
        bus.halt = 1'b0;
        step();
        check_eq("h2_halted", 32'(bus.halted), 32'h1);
        check_eq("h2_pc", bus.imemaddr, 32'h4);
        bus.flush = 1'b0;
        step();
        check_eq("h3_pc", bus.imemaddr, 32'h4);
        check_eq("h3_valid", 32'(bus.ifid_valid), 32'h0);
        check_eq("h3_cnt", bus.fetch_count, 32'd7);

        // Asynchronous reset mid-cycle
        #3;
        rst = 1'b1;
        #1;
        check_eq("ar_pc", bus.imemaddr, 32'h0);
        check_eq("ar_halted", 32'(bus.halted), 32'h0);
        check_eq("ar_cnt", bus.fetch_count, 32'h0);
        check_eq("ar_ren", 32'(bus.imemREN), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check_eq("post_pc", bus.imemaddr, 32'h4);
        check_eq("post_cnt", bus.fetch_count, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
